// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: register map,
// CTRL/STATUS bit positions, FSM states and reset constants.
package ro_meter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_TRIM_LSB = 1;
  localparam int CTRL_SEL_LSB  = 6;
  localparam int CTRL_GO       = 16;
  localparam int CTRL_ABORT    = 17;
  localparam int TRIM_W        = 5;
  localparam int SEL_W         = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  localparam int unsigned GATE_RESET = 1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2
  } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for the asynchronous oscillator input, followed by an
// edge flop that yields a one-cycle pulse per synchronised rising edge.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: non-blocking assignments make these three flops a true shift chain;
  // blocking ones would collapse them into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/ro_freq_meter.sv
// Wishbone-controlled frequency meter: drives the ring-oscillator control pins
// and counts synchronised rising edges of ro_in over a programmable gate window.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 16,
  // Gate width may exceed CNT_W so that edge-counter saturation is reachable.
  parameter int GATE_W        = CNT_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              ro_in,
  output logic              ro_start,
  output logic [TRIM_W-1:0] ro_trim,
  output logic [SEL_W-1:0]  ro_sel
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [GATE_W-1:0]  gate_reg;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   edge_next;
  logic [CNT_W-1:0]   count_reg;
  logic               edge_sat;
  logic               done;
  logic               ovf;
  logic               busy;
  logic               start_q;
  logic [TRIM_W-1:0]  trim_q;
  logic [SEL_W-1:0]   sel_q;
  logic               pulse;

  logic               req;
  logic               wr;
  logic               wr_ctrl;
  logic               wr_gate;
  logic               wr_status;
  logic               go_req;
  logic               abort_req;
  logic [31:0]        rd_data;
  logic               unused_ok;

  ro_edge_sync u_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .async_in (ro_in),
    .pulse    (pulse)
  );

  assign req       = wbs_cyc_i & wbs_stb_i;
  // A write commits on the edge that ends its ack cycle.
  assign wr        = req & wbs_we_i & wbs_ack_o;
  assign wr_ctrl   = wr && (wbs_adr_i[3:2] == REG_CTRL);
  assign wr_gate   = wr && (wbs_adr_i[3:2] == REG_GATE);
  assign wr_status = wr && (wbs_adr_i[3:2] == REG_STATUS);
  assign go_req    = wr_ctrl & wbs_dat_i[CTRL_GO];
  assign abort_req = wr_ctrl & wbs_dat_i[CTRL_ABORT];
  assign busy      = (state != ST_IDLE);

  assign ro_start  = start_q;
  assign ro_trim   = trim_q;
  assign ro_sel    = sel_q;

  assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  // Saturating increment: the edge that would wrap the counter flags ovf instead.
  always_comb begin
    edge_next = edge_cnt;
    edge_sat  = 1'b0;
    if (pulse) begin
      if (&edge_cnt) edge_sat  = 1'b1;
      else           edge_next = edge_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      REG_CTRL: begin
        rd_data[CTRL_START]                = start_q;
        rd_data[CTRL_TRIM_LSB +: TRIM_W]   = trim_q;
        rd_data[CTRL_SEL_LSB +: SEL_W]     = sel_q;
      end
      REG_GATE:   rd_data = 32'(gate_reg);
      REG_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done;
        rd_data[STAT_OVF]  = ovf;
      end
      REG_COUNT:  rd_data = 32'(count_reg);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      start_q    <= 1'b0;
      trim_q     <= '0;
      sel_q      <= '0;
      gate_reg   <= GATE_W'(GATE_RESET);
      gate_cnt   <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      count_reg  <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      wbs_ack_o <= req & ~wbs_ack_o;
      wbs_dat_o <= (req & ~wbs_ack_o) ? rd_data : '0;

      // The W1C clear sits before the FSM so a same-cycle set overrides it.
      if (wr_status) begin
        if (wbs_dat_i[STAT_DONE]) done <= 1'b0;
        if (wbs_dat_i[STAT_OVF])  ovf  <= 1'b0;
      end

      if (wr_ctrl && !busy) begin
        start_q <= wbs_dat_i[CTRL_START];
        trim_q  <= wbs_dat_i[CTRL_TRIM_LSB +: TRIM_W];
        sel_q   <= wbs_dat_i[CTRL_SEL_LSB +: SEL_W];
      end

      if (wr_gate && !busy) gate_reg <= wbs_dat_i[GATE_W-1:0];

      case (state)
        ST_IDLE: begin
          if (go_req) begin
            state      <= ST_SETTLE;
            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            edge_cnt   <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else if (settle_cnt == '0) begin
            if (gate_reg == '0) begin
              state     <= ST_IDLE;
              count_reg <= '0;
              done      <= 1'b1;
            end else begin
              state    <= ST_GATE;
              gate_cnt <= gate_reg - GATE_W'(1);
            end
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        ST_GATE: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            edge_cnt <= edge_next;
            if (edge_sat) ovf <= 1'b1;
            if (gate_cnt == '0) begin
              state     <= ST_IDLE;
              count_reg <= edge_next;
              done      <= 1'b1;
            end else begin
              gate_cnt <= gate_cnt - GATE_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
